// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer and its combinational core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

    // Command opcodes carried on cmd_op.
    typedef enum logic [2:0] {
        SH_NONE = 3'b000,
        SH_LSL  = 3'b001,
        SH_ASL  = 3'b010,
        SH_LSR  = 3'b011,
        SH_ASR  = 3'b100,
        SH_ROL  = 3'b101,
        SH_ROR  = 3'b110,
        SH_RSVD = 3'b111
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    // Default per-pass shift-count width and the largest shift done in one pass.
    localparam int unsigned DEF_STEP_W = 3;
    localparam int unsigned MAX_STEP   = (1 << DEF_STEP_W) - 1;

endpackage

// File: rtl/shift_core.sv
// Single-pass shifter/rotator: applies op by step bits to data.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   data_in  - operand (treated as signed for ASR)
//   op       - shift operation; NONE/RSVD pass data through
//   step     - shift count for this pass, 0..2**STEP_W-1
//   data_out - shifted result
module shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic [WIDTH-1:0]  data_in,
    input  shift_op_e         op,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  data_out
);

    // Rotates shift a doubled copy of the word; the wanted half holds the
    // bits that wrapped around.
    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;

    assign dbl_l = {data_in, data_in} << step;
    assign dbl_r = {data_in, data_in} >> step;

    always_comb begin
        data_out = data_in;
        case (op)
            SH_LSL,
            SH_ASL:  data_out = data_in << step;
            SH_LSR:  data_out = data_in >> step;
            SH_ASR:  data_out = $unsigned($signed(data_in) >>> step);
            SH_ROL:  data_out = dbl_l[2*WIDTH-1:WIDTH];
            SH_ROR:  data_out = dbl_r[WIDTH-1:0];
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven shift sequencer: clamps the amount and applies it as passes of at most 2**STEP_W-1 bits.
// Latency: result valid 1+k cycles after accept, k = ceil(eff_amt / max step).
// Backpressure: cmd_ready only in IDLE; result held in DONE until res_ready.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   cmd_valid/cmd_ready - command handshake; cmd_op, cmd_amt, cmd_data carry the command
//   res_valid/res_ready - result handshake; res_data result, res_err set for reserved op
//   busy                - high whenever not IDLE
//   op_count            - completed result handshakes, wrapping
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int AMT_W  = 8,
    parameter int STEP_W = DEF_STEP_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int LOG_W    = $clog2(WIDTH);
    // Remaining-count width must hold WIDTH itself (full-width clamp).
    localparam int REM_W    = LOG_W + 1;
    localparam int STEP_MAX = (1 << STEP_W) - 1;

    seq_state_e        state_q, state_d;
    shift_op_e         op_q,    op_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [REM_W-1:0]  rem_q,   rem_d;
    logic              err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    shift_op_e         cmd_op_e;
    logic [REM_W-1:0]  eff_amt;
    logic [STEP_W-1:0] step;
    logic [REM_W-1:0]  step_ext;
    logic [WIDTH-1:0]  core_out;

    assign cmd_op_e = shift_op_e'(cmd_op);

    // Effective amount: rotates wrap modulo WIDTH, shifts saturate at WIDTH
    // (anything beyond that gives the same result), none/reserved do nothing.
    always_comb begin
        eff_amt = '0;
        case (cmd_op_e)
            SH_ROL,
            SH_ROR:  eff_amt = REM_W'(cmd_amt[LOG_W-1:0]);
            SH_LSL,
            SH_ASL,
            SH_LSR,
            SH_ASR:  eff_amt = (cmd_amt >= AMT_W'(WIDTH)) ? REM_W'(WIDTH)
                                                          : cmd_amt[REM_W-1:0];
            default: eff_amt = '0;
        endcase
    end

    // Per-pass step = min(remaining, max step).
    assign step     = (rem_q > REM_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : rem_q[STEP_W-1:0];
    assign step_ext = REM_W'(step);

    shift_core #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_core (
        .data_in  (data_q),
        .op       (op_q),
        .step     (step),
        .data_out (core_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op_e;
                    data_d  = cmd_data;
                    rem_d   = eff_amt;
                    err_d   = (cmd_op_e == SH_RSVD);
                    state_d = (eff_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d = core_out;
                rem_d  = rem_q - step_ext;
                if (rem_q == step_ext) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= SH_NONE;
            data_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_data  = data_q;
    assign res_err   = err_q;
    assign op_count  = cnt_q;

endmodule
